// File: rtl/rpn_sequencer_pkg.sv
// Shared command, ALU-select, FSM-state and flag definitions for the RPN
// sequencer and its testbench.
package rpn_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_PUSH  = 2'b00,
    OP_EXEC  = 2'b01,
    OP_DROP  = 2'b10,
    OP_CLEAR = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    SEL_ADD = 3'b000,
    SEL_SUB = 3'b001,
    SEL_MUL = 3'b010,
    SEL_DIV = 3'b011,
    SEL_AND = 3'b100,
    SEL_OR  = 3'b101,
    SEL_XOR = 3'b110,
    SEL_NOT = 3'b111
  } alu_sel_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_MUL  = 2'b10,
    S_WB   = 2'b11
  } state_e;

  localparam int FLAG_COUT   = 0;
  localparam int FLAG_DIV0   = 1;
  localparam int FLAG_REM    = 2;
  localparam int FLAG_MULOVF = 3;

  // Stack entries an EXEC consumes: NOT is the only unary select.
  function automatic logic [3:0] operands_needed(input logic [2:0] sel);
    return (alu_sel_e'(sel) == SEL_NOT) ? 4'd1 : 4'd2;
  endfunction

endpackage

// File: rtl/rpn_sequencer_mul8.sv
// 8x8 shift-add multiplier: one multiplier bit per cycle, LSB first, 8 cycles.
// done is high during the final iteration; p holds the product the cycle after.
module rpn_mul8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        done,
  output logic [15:0] p
);

  logic [15:0] mcand_q;
  logic [15:0] acc_q;
  logic [7:0]  mplier_q;
  logic [2:0]  cnt_q;
  logic        run_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (start) begin
      mcand_q  <= {8'h00, a};
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 3'd1;
      if (cnt_q == 3'd7) run_q <= 1'b0;
    end
  end

  assign done = run_q && (cnt_q == 3'd7);
  assign p    = acc_q;

endmodule

// File: rtl/rpn_sequencer.sv
// RPN controller: keeps an operand stack, drives the external 8-bit ALU on
// EXEC and performs multiplication itself through rpn_mul8.
module rpn_sequencer
  import rpn_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [DW-1:0] cmd_data,
  input  logic [2:0]    cmd_sel,
  input  logic          cmd_cin,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_sel,
  output logic          alu_cin,
  input  logic [DW-1:0] alu_s,
  input  logic [2:0]    alu_flags,
  input  logic [DW-1:0] alu_resto,
  output logic [DW-1:0] top,
  output logic [3:0]    depth,
  output logic [3:0]    flags_q,
  output logic [DW-1:0] resto_q,
  output logic          err_underflow,
  output logic          err_overflow,
  output logic          busy
);

  localparam logic [3:0] DEPTH_W = 4'(DEPTH);

  state_e        state_q;
  alu_sel_e      sel_q;
  logic          cin_q;
  logic [DW-1:0] stk_q [DEPTH];
  logic [3:0]    depth_q;

  logic          accept;
  logic          have_ops;
  logic          mul_start;
  logic          mul_done;
  logic [15:0]   mul_p;

  logic [DW-1:0] result_d;
  logic [DW-1:0] push_d [DEPTH];
  logic [DW-1:0] pop_d  [DEPTH];
  logic [DW-1:0] fold_d [DEPTH];

  assign cmd_ready = (state_q == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign have_ops  = (depth_q >= operands_needed(cmd_sel));
  assign mul_start = accept && (cmd_op_e'(cmd_op) == OP_EXEC) && have_ops
                     && (alu_sel_e'(cmd_sel) == SEL_MUL);

  rpn_mul8 u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (stk_q[1]),
    .b     (stk_q[0]),
    .done  (mul_done),
    .p     (mul_p)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = '0;
    alu_cin = 1'b0;
    if (state_q == S_EXEC) begin
      alu_sel = sel_q;
      alu_cin = cin_q;
      if (sel_q == SEL_NOT) begin
        alu_a = stk_q[0];
      end else begin
        alu_a = stk_q[1];
        alu_b = stk_q[0];
      end
    end
  end

  // Candidate next stacks: push, pop-one, and pop-two-push-result (fold).
  always_comb begin
    result_d  = (state_q == S_WB) ? mul_p[7:0] : alu_s;
    push_d[0] = cmd_data;
    for (int i = 1; i < DEPTH; i++) push_d[i] = stk_q[i-1];
    for (int i = 0; i < DEPTH - 1; i++) pop_d[i] = stk_q[i+1];
    pop_d[DEPTH-1] = '0;
    fold_d    = pop_d;
    fold_d[0] = result_d;
  end

  // NOTE: state uses non-blocking assignments so all registers update from
  // the same pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      sel_q         <= SEL_ADD;
      cin_q         <= 1'b0;
      depth_q       <= '0;
      flags_q       <= '0;
      resto_q       <= '0;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
      busy          <= 1'b0;
      // NOTE: the stack is a small register file that must read as zero after
      // reset, so each entry is reset explicitly (unlike a RAM).
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            unique case (cmd_op_e'(cmd_op))
              OP_PUSH: begin
                if (depth_q < DEPTH_W) begin
                  stk_q   <= push_d;
                  depth_q <= depth_q + 4'd1;
                end else begin
                  err_overflow <= 1'b1;
                end
              end
              OP_DROP: begin
                if (depth_q != 4'd0) begin
                  stk_q   <= pop_d;
                  depth_q <= depth_q - 4'd1;
                end else begin
                  err_underflow <= 1'b1;
                end
              end
              OP_CLEAR: begin
                for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
                depth_q       <= '0;
                flags_q       <= '0;
                resto_q       <= '0;
                err_underflow <= 1'b0;
                err_overflow  <= 1'b0;
              end
              OP_EXEC: begin
                if (!have_ops) begin
                  err_underflow <= 1'b1;
                end else begin
                  sel_q   <= alu_sel_e'(cmd_sel);
                  cin_q   <= cmd_cin;
                  busy    <= 1'b1;
                  state_q <= (alu_sel_e'(cmd_sel) == SEL_MUL) ? S_MUL : S_EXEC;
                end
              end
              default: ;
            endcase
          end
        end
        S_EXEC: begin
          flags_q <= {1'b0, alu_flags};
          resto_q <= alu_resto;
          // A divide by zero leaves the operands in place for the requester.
          if (!alu_flags[FLAG_DIV0]) begin
            if (sel_q == SEL_NOT) begin
              stk_q[0] <= result_d;
            end else begin
              stk_q   <= fold_d;
              depth_q <= depth_q - 4'd1;
            end
          end
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        S_MUL: begin
          if (mul_done) state_q <= S_WB;
        end
        S_WB: begin
          stk_q   <= fold_d;
          depth_q <= depth_q - 4'd1;
          flags_q <= {|mul_p[15:8], 3'b000};
          resto_q <= '0;
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign top   = (depth_q == 4'd0) ? '0 : stk_q[0];
  assign depth = depth_q;

endmodule

// File: tb/tb_rpn_sequencer.sv
// Bench for rpn_sequencer: models the external ALU and checks directed
// scenarios plus a random command stream against a queue-based stack model.
module tb_rpn_sequencer;
  import rpn_sequencer_pkg::*;

  localparam int STK_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [2:0] cmd_sel;
  logic       cmd_cin;
  logic [7:0] alu_a, alu_b, alu_s, alu_resto;
  logic [2:0] alu_sel, alu_flags;
  logic       alu_cin;
  logic [7:0] top, resto_q;
  logic [3:0] depth, flags_q;
  logic       err_underflow, err_overflow, busy;

  always #5 clk = ~clk;

  rpn_sequencer #(.DEPTH(STK_DEPTH), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_sel(cmd_sel), .cmd_cin(cmd_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_s(alu_s), .alu_flags(alu_flags), .alu_resto(alu_resto),
    .top(top), .depth(depth), .flags_q(flags_q), .resto_q(resto_q),
    .err_underflow(err_underflow), .err_overflow(err_overflow), .busy(busy)
  );

  typedef struct packed {
    logic [7:0] s;
    logic [2:0] f;
    logic [7:0] r;
  } alu_res_t;

  // External ALU behaviour; select 010 deliberately returns zero.
  function automatic alu_res_t alu_ref(input logic [2:0] sel, input logic [7:0] a,
                                       input logic [7:0] b, input logic cin);
    alu_res_t res;
    logic [8:0] w;
    res = '0;
    case (sel)
      3'd0: begin w = 9'(a) + 9'(b) + 9'(cin); res.s = w[7:0]; res.f[0] = w[8]; end
      3'd1: begin w = 9'(a) - 9'(b) - 9'(cin); res.s = w[7:0]; res.f[0] = w[8]; end
      3'd3: begin
        if (b == 8'd0) res.f[1] = 1'b1;
        else begin res.s = a / b; res.r = a % b; res.f[2] = (res.r != 8'd0); end
      end
      3'd4: res.s = a & b;
      3'd5: res.s = a | b;
      3'd6: res.s = a ^ b;
      3'd7: res.s = ~a;
      default: ;
    endcase
    return res;
  endfunction

  alu_res_t alu_out;
  always_comb alu_out = alu_ref(alu_sel, alu_a, alu_b, alu_cin);
  assign alu_s     = alu_out.s;
  assign alu_flags = alu_out.f;
  assign alu_resto = alu_out.r;

  int n_vec = 0;
  int n_err = 0;

  int         ob_busy, ob_rlow;
  logic [7:0] ob_a, ob_b;
  logic [2:0] ob_sel;

  logic [7:0] m_stk[$];
  logic [3:0] m_flags;
  logic [7:0] m_resto;
  logic       m_uf, m_of;
  int         exp_busy;
  logic [7:0] exp_a, exp_b;

  // Present one command, then follow it until the block is idle again.
  task automatic issue(input logic [1:0] op, input logic [7:0] data,
                       input logic [2:0] sel, input logic cin);
    int guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 40) begin @(negedge clk); guard++; end
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_sel = sel; cmd_cin = cin;
    @(negedge clk);
    cmd_valid = 1'b0;
    ob_a = alu_a; ob_b = alu_b; ob_sel = alu_sel;
    ob_busy = 0; ob_rlow = 0;
    while (busy && ob_busy < 30) begin
      ob_busy++;
      if (!cmd_ready) ob_rlow++;
      @(negedge clk);
    end
  endtask

  task automatic model_clear();
    m_stk.delete(); m_flags = '0; m_resto = '0; m_uf = 1'b0; m_of = 1'b0;
  endtask

  // Stack model: m_stk[0] is the top of stack.
  task automatic model_apply(input logic [1:0] op, input logic [7:0] data,
                             input logic [2:0] sel, input logic cin);
    alu_res_t   r;
    logic [15:0] p;
    int need;
    exp_busy = 0; exp_a = '0; exp_b = '0;
    case (op)
      OP_PUSH:  if (m_stk.size() < STK_DEPTH) m_stk.push_front(data); else m_of = 1'b1;
      OP_DROP:  if (m_stk.size() > 0) void'(m_stk.pop_front()); else m_uf = 1'b1;
      OP_CLEAR: model_clear();
      default: begin
        need = (sel == 3'd7) ? 1 : 2;
        if (m_stk.size() < need) m_uf = 1'b1;
        else if (sel == 3'd2) begin
          exp_busy = 9;
          p = 16'(m_stk[1]) * 16'(m_stk[0]);
          void'(m_stk.pop_front()); void'(m_stk.pop_front());
          m_stk.push_front(p[7:0]);
          m_flags = {(p[15:8] != 8'd0), 3'b000};
          m_resto = '0;
        end else begin
          exp_busy = 1;
          exp_a = (need == 1) ? m_stk[0] : m_stk[1];
          exp_b = (need == 1) ? 8'd0 : m_stk[0];
          r = alu_ref(sel, exp_a, exp_b, cin);
          m_flags = {1'b0, r.f};
          m_resto = r.r;
          if (!r.f[1]) begin
            if (need == 1) m_stk[0] = r.s;
            else begin
              void'(m_stk.pop_front()); void'(m_stk.pop_front());
              m_stk.push_front(r.s);
            end
          end
        end
      end
    endcase
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_sel = '0; cmd_cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_vec++; if (depth !== 4'd0) begin n_err++; $display("FAIL reset_depth: got %0d want 0", depth); end
    n_vec++; if (top !== 8'd0) begin n_err++; $display("FAIL reset_top: got %0d want 0", top); end
    n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if ({flags_q, resto_q, err_underflow, err_overflow} !== 14'd0) begin
      n_err++; $display("FAIL reset_status: flags %b resto %0d uf %b of %b want all 0",
                        flags_q, resto_q, err_underflow, err_overflow); end
    n_vec++; if ({alu_a, alu_b, alu_sel, alu_cin} !== 20'd0) begin
      n_err++; $display("FAIL reset_alu_idle: a %0d b %0d sel %0d want 0", alu_a, alu_b, alu_sel); end
  endtask

  task automatic test_add();
    issue(OP_CLEAR, 0, 0, 0);
    issue(OP_PUSH, 8'd5, 0, 0);
    issue(OP_PUSH, 8'd3, 0, 0);
    issue(OP_EXEC, 0, 3'd0, 1'b0);
    n_vec++; if (top !== 8'd8) begin n_err++; $display("FAIL add_top: got %0d want 8", top); end
    n_vec++; if (depth !== 4'd1) begin n_err++; $display("FAIL add_depth: got %0d want 1", depth); end
    n_vec++; if (flags_q !== 4'b0000) begin n_err++; $display("FAIL add_flags: got %b want 0000", flags_q); end
    n_vec++; if (ob_busy !== 1) begin n_err++; $display("FAIL add_busy_cycles: got %0d want 1", ob_busy); end
    n_vec++; if (ob_rlow !== 1) begin n_err++; $display("FAIL add_ready_low: got %0d want 1", ob_rlow); end
    n_vec++; if ({ob_a, ob_b} !== {8'd5, 8'd3}) begin
      n_err++; $display("FAIL add_operands: got a=%0d b=%0d want a=5 b=3", ob_a, ob_b); end
  endtask

  task automatic test_mul();
    issue(OP_CLEAR, 0, 0, 0);
    issue(OP_PUSH, 8'd20, 0, 0);
    issue(OP_PUSH, 8'd15, 0, 0);
    issue(OP_EXEC, 0, 3'd2, 1'b0);
    n_vec++; if (ob_busy !== 9) begin n_err++; $display("FAIL mul_busy_cycles: got %0d want 9", ob_busy); end
    n_vec++; if (top !== 8'd44) begin n_err++; $display("FAIL mul_top_ovf: got %0d want 44", top); end
    n_vec++; if (flags_q !== 4'b1000) begin n_err++; $display("FAIL mul_flags_ovf: got %b want 1000", flags_q); end
    n_vec++; if (depth !== 4'd1) begin n_err++; $display("FAIL mul_depth: got %0d want 1", depth); end
    issue(OP_CLEAR, 0, 0, 0);
    issue(OP_PUSH, 8'd12, 0, 0);
    issue(OP_PUSH, 8'd10, 0, 0);
    issue(OP_EXEC, 0, 3'd2, 1'b0);
    n_vec++; if (top !== 8'd120) begin n_err++; $display("FAIL mul_top: got %0d want 120", top); end
    n_vec++; if (flags_q !== 4'b0000) begin n_err++; $display("FAIL mul_flags: got %b want 0000", flags_q); end
  endtask

  task automatic test_div_zero();
    issue(OP_CLEAR, 0, 0, 0);
    issue(OP_PUSH, 8'd9, 0, 0);
    issue(OP_PUSH, 8'd0, 0, 0);
    issue(OP_EXEC, 0, 3'd3, 1'b0);
    n_vec++; if (depth !== 4'd2) begin n_err++; $display("FAIL div0_depth: got %0d want 2", depth); end
    n_vec++; if (top !== 8'd0) begin n_err++; $display("FAIL div0_st0: got %0d want 0", top); end
    n_vec++; if (flags_q !== 4'b0010) begin n_err++; $display("FAIL div0_flags: got %b want 0010", flags_q); end
    issue(OP_DROP, 0, 0, 0);
    n_vec++; if (top !== 8'd9) begin n_err++; $display("FAIL div0_st1: got %0d want 9", top); end
  endtask

  task automatic test_errors();
    issue(OP_CLEAR, 0, 0, 0);
    issue(OP_EXEC, 0, 3'd0, 1'b0);
    n_vec++; if (err_underflow !== 1'b1) begin n_err++; $display("FAIL uf_flag: got %b want 1", err_underflow); end
    n_vec++; if (depth !== 4'd0) begin n_err++; $display("FAIL uf_depth: got %0d want 0", depth); end
    n_vec++; if (ob_busy !== 0) begin n_err++; $display("FAIL uf_busy: got %0d want 0", ob_busy); end
    for (int i = 1; i <= 5; i++) issue(OP_PUSH, 8'(i), 0, 0);
    n_vec++; if (depth !== 4'd4) begin n_err++; $display("FAIL of_depth: got %0d want 4", depth); end
    n_vec++; if (err_overflow !== 1'b1) begin n_err++; $display("FAIL of_flag: got %b want 1", err_overflow); end
    n_vec++; if (top !== 8'd4) begin n_err++; $display("FAIL of_top: got %0d want 4", top); end
    issue(OP_CLEAR, 0, 0, 0);
    n_vec++; if ({depth, top, err_underflow, err_overflow, flags_q, resto_q} !== 26'd0) begin
      n_err++; $display("FAIL clear_all: depth %0d top %0d uf %b of %b flags %b want all 0",
                        depth, top, err_underflow, err_overflow, flags_q); end
  endtask

  task automatic test_reset_mid_mul();
    issue(OP_CLEAR, 0, 0, 0);
    issue(OP_PUSH, 8'd200, 0, 0);
    issue(OP_PUSH, 8'd100, 0, 0);
    issue(OP_EXEC, 0, 3'd0, 1'b0);
    n_vec++; if (flags_q !== 4'b0001) begin n_err++; $display("FAIL carry_flag: got %b want 0001", flags_q); end
    issue(OP_PUSH, 8'd2, 0, 0);
    issue(OP_PUSH, 8'd3, 0, 0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_EXEC; cmd_sel = 3'd2; cmd_cin = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL midmul_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_vec++; if ({depth, busy, cmd_ready, flags_q} !== {4'd0, 1'b0, 1'b1, 4'd0}) begin
      n_err++; $display("FAIL midmul_reset: depth %0d busy %b ready %b flags %b want 0 0 1 0000",
                        depth, busy, cmd_ready, flags_q); end
  endtask

  task automatic test_unary();
    issue(OP_CLEAR, 0, 0, 0);
    issue(OP_PUSH, 8'hF0, 0, 0);
    issue(OP_EXEC, 0, 3'd7, 1'b0);
    n_vec++; if ({ob_a, ob_b} !== {8'hF0, 8'h00}) begin
      n_err++; $display("FAIL not_operands: got a=%h b=%h want a=f0 b=00", ob_a, ob_b); end
    n_vec++; if (top !== 8'h0F) begin n_err++; $display("FAIL not_top: got %h want 0f", top); end
    n_vec++; if (depth !== 4'd1) begin n_err++; $display("FAIL not_depth: got %0d want 1", depth); end
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [7:0] d;
    logic [2:0] sel;
    logic       cin;
    int         r;
    issue(OP_CLEAR, 0, 0, 0);
    model_clear();
    for (int n = 0; n < 200; n++) begin
      r   = $urandom_range(0, 19);
      op  = (r < 8) ? OP_PUSH : (r < 15) ? OP_EXEC : (r < 18) ? OP_DROP : OP_CLEAR;
      d   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      sel = 3'($urandom_range(0, 7));
      cin = 1'($urandom_range(0, 1));
      model_apply(op, d, sel, cin);
      issue(op, d, sel, cin);
      n_vec++; if (ob_busy !== exp_busy || ob_rlow !== exp_busy) begin n_err++;
        $display("FAIL rnd_busy[%0d]: got busy %0d ready_low %0d want %0d", n, ob_busy, ob_rlow, exp_busy); end
      if (exp_busy == 1) begin
        n_vec++; if ({ob_a, ob_b, ob_sel} !== {exp_a, exp_b, sel}) begin n_err++;
          $display("FAIL rnd_alu_in[%0d]: got %h %h %0d want %h %h %0d", n, ob_a, ob_b, ob_sel, exp_a, exp_b, sel); end
      end
      n_vec++; if (depth !== 4'(m_stk.size())) begin n_err++;
        $display("FAIL rnd_depth[%0d]: got %0d want %0d", n, depth, m_stk.size()); end
      n_vec++; if (top !== ((m_stk.size() > 0) ? m_stk[0] : 8'd0)) begin n_err++;
        $display("FAIL rnd_top[%0d]: got %h want %h", n, top, (m_stk.size() > 0) ? m_stk[0] : 8'd0); end
      n_vec++; if ({flags_q, resto_q} !== {m_flags, m_resto}) begin n_err++;
        $display("FAIL rnd_flags[%0d]: got %b/%h want %b/%h", n, flags_q, resto_q, m_flags, m_resto); end
      n_vec++; if ({err_underflow, err_overflow} !== {m_uf, m_of}) begin n_err++;
        $display("FAIL rnd_err[%0d]: got uf %b of %b want %b %b", n, err_underflow, err_overflow, m_uf, m_of); end
      n_vec++; if ({alu_a, alu_b, alu_sel, alu_cin} !== 20'd0) begin n_err++;
        $display("FAIL rnd_alu_idle[%0d]: got a %h b %h sel %0d want 0", n, alu_a, alu_b, alu_sel); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div_zero();
    test_errors();
    test_reset_mid_mul();
    test_unary();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
